// File: rtl/sincos_coeff_table.sv
// sincos_coeff_table: stream-loaded sine/cosine coefficient RAMs with registered, validity-gated reads
module sincos_coeff_table #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int COEF_W = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              load_valid,
    input  logic [COEF_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_err,
    input  logic [ADDR_W-1:0] addr_sin,
    input  logic [ADDR_W-1:0] addr_cos,
    output logic [COEF_W-1:0] coeffs_sin_out,
    output logic [COEF_W-1:0] coeffs_cos_out,
    output logic              tables_valid
);
    typedef enum logic [1:0] {EMPTY, LOAD_SIN, LOAD_COS, READY} state_t;
    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [COEF_W-1:0] sin_mem [DEPTH];
    logic [COEF_W-1:0] cos_mem [DEPTH];
    logic              accept;
    logic              last;
    assign accept = load_valid & load_ready & ~cfg_start;
    assign last   = wr_addr == ADDR_W'(DEPTH - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            wr_addr      <= '0;
            load_ready   <= 1'b0;
            load_err     <= 1'b0;
            tables_valid <= 1'b0;
        end else if (cfg_start) begin
            state        <= LOAD_SIN;
            wr_addr      <= '0;
            load_ready   <= 1'b1;
            load_err     <= 1'b0;
            tables_valid <= 1'b0;
        end else if (accept) begin
            wr_addr <= wr_addr + 1'b1;
            if (last) begin
                state        <= state == LOAD_SIN ? LOAD_COS : READY;
                load_ready   <= state == LOAD_SIN;
                tables_valid <= state == LOAD_COS;
            end
        end else if (load_valid & ~load_ready) begin
            load_err <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (accept && state == LOAD_SIN) sin_mem[wr_addr] <= load_data;
        if (accept && state == LOAD_COS) cos_mem[wr_addr] <= load_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coeffs_sin_out <= '0;
            coeffs_cos_out <= '0;
        end else begin
            coeffs_sin_out <= tables_valid ? sin_mem[addr_sin] : '0;
            coeffs_cos_out <= tables_valid ? cos_mem[addr_cos] : '0;
        end
    end
endmodule
